ibex_rf_writeback: RTL

Write-side sequencer for the Ibex register file: the single block that drives the file's write port (`waddr_a`/`wdata_a`/`we_a`). After reset, and on request, it zeroes every architectural register. In normal operation it arbitrates between the EX-stage result and late LSU load data, holding EX results in a one-entry skid buffer. It guarantees one registered write per cycle and correct older-first ordering.

---
 rtl/ibex_rf_writeback.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ibex_rf_writeback.sv
`default_nettype none
// ============================================================================
// Module   : ibex_rf_writeback
// Purpose  : Write-port sequencer for the Ibex register file. Zeroes every
//            architectural register after reset or on request, then
//            arbitrates between EX results and late LSU load data, using a
//            one-entry skid buffer so the older load always lands first.
// Revision : 1.0 - initial release
// ============================================================================
module ibex_rf_writeback #(
  parameter int unsigned DataWidth = 32,
  parameter bit          RV32E     = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 init_req_i,
  output logic                 init_done_o,
  input  logic                 ex_valid_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,
  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 lsu_ready_o,
  output logic [4:0]           waddr_a_o,
  output logic [DataWidth-1:0] wdata_a_o,
  output logic                 we_a_o,
  output logic                 illegal_waddr_o
);

  // Highest architectural register index; the zeroing sweep stops here.
  localparam logic [4:0] c_last_addr = RV32E ? 5'd15 : 5'd31;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e               r_state, w_state_nxt;
  logic [4:0]           r_cnt, w_cnt_nxt;
  logic                 r_buf_valid, w_buf_valid_nxt;
  logic [4:0]           r_buf_addr, w_buf_addr_nxt;
  logic [DataWidth-1:0] r_buf_data, w_buf_data_nxt;
  logic                 r_init_req, w_init_req_nxt;
  logic                 r_we, w_we_nxt;
  logic [4:0]           r_waddr, w_waddr_nxt;
  logic [DataWidth-1:0] r_wdata, w_wdata_nxt;
  logic                 r_illegal, w_illegal_nxt;
  logic                 w_run;
  logic                 w_ex_acc;

  // Address beyond the 16-entry file when built as RV32E.
  function automatic logic f_illegal(input logic [4:0] addr);
    return RV32E && addr[4];
  endfunction

  // Writes that must never reach the file: x0 or an out-of-range register.
  function automatic logic f_drop(input logic [4:0] addr);
    return (addr == 5'd0) || f_illegal(addr);
  endfunction

  assign w_run       = (r_state == ST_RUN);
  assign init_done_o = w_run;
  assign lsu_ready_o = w_run;
  assign ex_ready_o  = w_run && !r_buf_valid && !r_init_req;
  assign w_ex_acc    = ex_valid_i && ex_ready_o;

  assign we_a_o          = r_we;
  assign waddr_a_o       = r_waddr;
  assign wdata_a_o       = r_wdata;
  assign illegal_waddr_o = r_illegal;

  // Next-state and write-port selection; LSU beats buffer beats fresh EX.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_buf_valid_nxt = r_buf_valid;
    w_buf_addr_nxt  = r_buf_addr;
    w_buf_data_nxt  = r_buf_data;
    w_init_req_nxt  = r_init_req;
    w_we_nxt        = 1'b0;
    w_waddr_nxt     = r_waddr;
    w_wdata_nxt     = r_wdata;
    w_illegal_nxt   = 1'b0;

    case (r_state)
      ST_INIT: begin
        w_we_nxt    = 1'b1;
        w_waddr_nxt = r_cnt;
        w_wdata_nxt = '0;
        w_cnt_nxt   = r_cnt + 5'd1;
        if (r_cnt == c_last_addr) begin
          w_state_nxt = ST_RUN;
        end
      end

      default: begin
        if (init_req_i) begin
          w_init_req_nxt = 1'b1;
        end

        if (lsu_valid_i) begin
          // The load belongs to the older instruction, so it goes first and
          // any EX result accepted alongside it is parked in the buffer.
          w_we_nxt      = !f_drop(lsu_waddr_i);
          w_waddr_nxt   = lsu_waddr_i;
          w_wdata_nxt   = lsu_wdata_i;
          w_illegal_nxt = f_illegal(lsu_waddr_i);
          if (w_ex_acc) begin
            w_illegal_nxt = w_illegal_nxt || f_illegal(ex_waddr_i);
            if (!f_drop(ex_waddr_i)) begin
              w_buf_valid_nxt = 1'b1;
              w_buf_addr_nxt  = ex_waddr_i;
              w_buf_data_nxt  = ex_wdata_i;
            end
          end
        end else if (r_buf_valid) begin
          w_we_nxt        = 1'b1;
          w_waddr_nxt     = r_buf_addr;
          w_wdata_nxt     = r_buf_data;
          w_buf_valid_nxt = 1'b0;
        end else if (w_ex_acc) begin
          w_we_nxt      = !f_drop(ex_waddr_i);
          w_waddr_nxt   = ex_waddr_i;
          w_wdata_nxt   = ex_wdata_i;
          w_illegal_nxt = f_illegal(ex_waddr_i);
        end

        // Re-zeroing waits until nothing older is left to write.
        if (r_init_req && !r_buf_valid && !lsu_valid_i) begin
          w_state_nxt    = ST_INIT;
          w_cnt_nxt      = 5'd1;
          w_init_req_nxt = 1'b0;
        end
      end
    endcase
  end

  // State, skid buffer and registered write port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_INIT;
      r_cnt       <= 5'd1;
      r_buf_valid <= 1'b0;
      r_buf_addr  <= 5'd0;
      r_buf_data  <= '0;
      r_init_req  <= 1'b0;
      r_we        <= 1'b0;
      r_waddr     <= 5'd0;
      r_wdata     <= '0;
      r_illegal   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_buf_valid <= w_buf_valid_nxt;
      r_buf_addr  <= w_buf_addr_nxt;
      r_buf_data  <= w_buf_data_nxt;
      r_init_req  <= w_init_req_nxt;
      r_we        <= w_we_nxt;
      r_waddr     <= w_waddr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_illegal   <= w_illegal_nxt;
    end
  end

endmodule
`default_nettype wire
